// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame controller for a radix-4 FFT datapath
// Sequences B = N/4 input beats, tracks datapath latency and flags protocol errors.
module fft_frame_ctrl #(
    parameter int N_LOG2 = 6,
    parameter int LAT    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_LOG2-3:0] beat_idx,
    output logic [N_LOG2-3:0] tw_addr,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BW = N_LOG2 - 2;
    localparam logic [BW-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   beat_cnt;
    logic [BW-1:0]   out_cnt;
    logic [LAT-1:0]  sr;
    logic            err_r;
    logic            accept;
    logic            start_acc;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign start_acc = start & (state == IDLE);
    assign beat_idx  = beat_cnt;
    assign out_valid = sr[LAT-1];
    assign out_last  = out_valid & (out_cnt == LAST_BEAT);
    assign err       = err_r;

    always_comb begin
        tw_addr = '0;
        for (int i = 0; i < BW; i++) begin
            tw_addr[i] = beat_cnt[BW-1-i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (accept && (beat_cnt == LAST_BEAT)) state_nxt = DRAIN;
            DRAIN:   if (out_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // beat_cnt wraps to 0 naturally on the last beat of the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            out_cnt  <= '0;
            err_r    <= 1'b0;
        end else begin
            if (start_acc) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (start_acc) begin
                out_cnt <= '0;
            end else if (out_valid) begin
                out_cnt <= out_cnt + 1'b1;
            end

            // a beat offered alongside the start is still an error
            if (start_acc) begin
                err_r <= in_valid;
            end else if (in_valid && !in_ready) begin
                err_r <= 1'b1;
            end
        end
    end

    generate
        if (LAT == 1) begin : g_sr_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sr <= '0;
                end else begin
                    sr <= accept;
                end
            end
        end else begin : g_sr_multi
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[LAT-2:0], accept};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed bench for fft_frame_ctrl
// Instance a uses default parameters, instance b the corner N_LOG2=4, LAT=1.
module tb_fft_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, iv_a, start_b, iv_b;
    logic       ir_a, ov_a, ol_a, busy_a, done_a, err_a;
    logic [3:0] bi_a, tw_a;
    logic       ir_b, ov_b, ol_b, busy_b, done_b, err_b;
    logic [1:0] bi_b, tw_b;

    int n_cmp = 0;
    int n_bad = 0;

    fft_frame_ctrl #(.N_LOG2(6), .LAT(12)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(iv_a),
        .in_ready(ir_a), .beat_idx(bi_a), .tw_addr(tw_a),
        .out_valid(ov_a), .out_last(ol_a), .busy(busy_a),
        .done(done_a), .err(err_a)
    );

    fft_frame_ctrl #(.N_LOG2(4), .LAT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(iv_b),
        .in_ready(ir_b), .beat_idx(bi_b), .tw_addr(tw_b),
        .out_valid(ov_b), .out_last(ol_b), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    typedef struct packed {
        logic       st;
        logic       iv;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t v(input logic st, input logic iv, input logic ir,
                               input logic [1:0] bi, input logic [1:0] tw,
                               input logic ov, input logic ol, input logic bz,
                               input logic dn, input logic er);
        vec_t r;
        r.st  = st;
        r.iv  = iv;
        r.exp = {ir, bi, tw, ov, ol, bz, dn, er};
        return r;
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] act_a();
        return {2'b00, ir_a, bi_a, tw_a, ov_a, ol_a, busy_a, done_a, err_a};
    endfunction

    // ga/gb: beat numbers followed by a one-cycle gap; start_at: extra start pulse;
    // bad_off: cycles after the last beat to drive a stray in_valid; err0: err before start
    task automatic run_main(input string tag, input int ga, input int gb,
                            input int start_at, input int bad_off, input logic err0);
        int acc[16];
        int cyc;
        int last;
        int bad;
        cyc = 1;
        for (int k = 0; k < 16; k++) begin
            acc[k] = cyc;
            cyc++;
            if (k == ga || k == gb) cyc++;
        end
        last = acc[15];
        bad  = (bad_off >= 0) ? last + bad_off : -1;
        for (int c = 0; c <= last + 13; c++) begin
            int          nb;
            logic        acc_now, ov_e, ld, er_e;
            logic [3:0]  bi_e;
            logic [15:0] exp;
            nb = 0; acc_now = 1'b0; ov_e = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (acc[k] < c) nb++;
                if (acc[k] == c) acc_now = 1'b1;
                if (acc[k] + 12 == c) ov_e = 1'b1;
            end
            ld   = (c >= 1) && (c <= last);
            bi_e = ld ? 4'(nb) : 4'd0;
            er_e = (c == 0) ? err0 : ((bad >= 0) && (c > bad));
            exp  = {2'b00, ld, bi_e, rev4(bi_e), ov_e, (c == last + 12), (c >= 1),
                    (c == last + 13), er_e};
            check($sformatf("%s c%0d", tag, c), act_a(), exp);
            start_a = (c == 0) || (c == start_at);
            iv_a    = acc_now || (c == bad);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        iv_a    = 1'b0;
    endtask

    initial begin
        int stray;
        rst = 1'b0; start_a = 1'b0; iv_a = 1'b0; start_b = 1'b0; iv_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", act_a(), 16'h0000);
        check("reset_b", {6'd0, ir_b, bi_b, tw_b, ov_b, ol_b, busy_b, done_b, err_b}, 16'h0000);
        rst = 1'b1;
        @(posedge clk); #1;

        //           st iv ir bi tw ov ol bz dn er
        tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl[2]  = v(0, 1, 1, 1, 2, 1, 0, 1, 0, 0);
        tbl[3]  = v(0, 1, 1, 2, 1, 1, 0, 1, 0, 0);
        tbl[4]  = v(0, 1, 1, 3, 3, 1, 0, 1, 0, 0);
        tbl[5]  = v(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[7]  = v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = v(1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        tbl[9]  = v(0, 0, 1, 1, 2, 1, 0, 1, 0, 1);
        tbl[10] = v(0, 1, 1, 1, 2, 0, 0, 1, 0, 1);
        tbl[11] = v(0, 1, 1, 2, 1, 1, 0, 1, 0, 1);
        tbl[12] = v(0, 1, 1, 3, 3, 1, 0, 1, 0, 1);
        tbl[13] = v(0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
        tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        tbl[15] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[16] = v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 17; i++) begin
            check($sformatf("corner row %0d", i),
                  {6'd0, ir_b, bi_b, tw_b, ov_b, ol_b, busy_b, done_b, err_b},
                  {6'd0, tbl[i].exp});
            start_b = tbl[i].st;
            iv_b    = tbl[i].iv;
            @(posedge clk); #1;
        end
        start_b = 1'b0;
        iv_b    = 1'b0;

        run_main("plain", -1, -1, -1, -1, 1'b0);
        run_main("gaps", 3, 9, -1, -1, 1'b0);

        iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        check("idle_iv_err", act_a(), 16'h0001);
        @(posedge clk); #1;
        check("idle_err_held", act_a(), 16'h0001);

        run_main("errs", -1, -1, 5, 3, 1'b1);
        run_main("clear", -1, -1, -1, -1, 1'b1);

        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        iv_a    = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("pre_reset_idx", {12'd0, bi_a}, 16'd7);
        #3 rst = 1'b0;
        #1;
        iv_a = 1'b0;
        check("async_reset", act_a(), 16'h0000);
        @(posedge clk); #1;
        check("reset_hold", act_a(), 16'h0000);
        rst = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ov_a || ir_a || busy_a) stray++;
        end
        check("no_stray_after_reset", 16'(stray), 16'd0);

        run_main("restart", -1, -1, -1, -1, 1'b0);
        check("final_idle", act_a(), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
